conv_window_seq: RTL and testbench

//  Upstream sequencer for the border-detect stage of the conv layer.
//  - Walks pixel index i over a matrix x matrix feature map and drives i/go to border.
//  - Consumes the registered edge code prov that border returns.
//  - Emits the nine 3x3 window taps per pixel, with read addresses and a zero-pad flag, to the MAC stage.
//  - Top/bottom edges are detected locally; left/right edges come from prov.

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_tap_calc.sv | 45 ++++
 rtl/conv_window_seq.sv | 132 +++++++++++++
 tb/tb_conv_window_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv window sequencer: FSM encoding,
// border edge codes and the 3x3 tap offset decode.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    TAPS   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] PROV_LEFT    = 2'b11;
  localparam logic [1:0] PROV_RIGHT   = 2'b10;
  localparam int         TAPS_PER_WIN = 9;
  localparam logic [3:0] TAP_LAST     = 4'(TAPS_PER_WIN - 1);

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } tap_ofs_t;

  // Row-major 3x3 walk: dr = idx/3 - 1, dc = idx%3 - 1.
  function automatic tap_ofs_t tap_decode(input logic [3:0] idx);
    tap_ofs_t o;
    case (idx)
      4'd0:    begin o.dr = -2'sd1; o.dc = -2'sd1; end
      4'd1:    begin o.dr = -2'sd1; o.dc =  2'sd0; end
      4'd2:    begin o.dr = -2'sd1; o.dc =  2'sd1; end
      4'd3:    begin o.dr =  2'sd0; o.dc = -2'sd1; end
      4'd4:    begin o.dr =  2'sd0; o.dc =  2'sd0; end
      4'd5:    begin o.dr =  2'sd0; o.dc =  2'sd1; end
      4'd6:    begin o.dr =  2'sd1; o.dc = -2'sd1; end
      4'd7:    begin o.dr =  2'sd1; o.dc =  2'sd0; end
      4'd8:    begin o.dr =  2'sd1; o.dc =  2'sd1; end
      default: begin o.dr =  2'sd0; o.dc =  2'sd0; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/conv_tap_calc.sv
// Combinational pad/address generation for one 3x3 window tap.
module conv_tap_calc
  import conv_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 10,
  parameter int MAT_W  = 5
) (
  input  logic [3:0]        tap_idx,
  input  logic [IDX_W-1:0]  i,
  input  logic [MAT_W-1:0]  matrix,
  input  logic [IDX_W-1:0]  lim_bot,
  input  logic [1:0]        prov,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              tap_pad,
  output logic [ADDR_W-1:0] rd_addr
);

  tap_ofs_t          w_ofs;
  logic              w_up, w_dn, w_lf, w_rt;
  logic [ADDR_W-1:0] w_sum;

  assign w_ofs = tap_decode(tap_idx);
  assign w_up  = (w_ofs.dr == -2'sd1);
  assign w_dn  = (w_ofs.dr ==  2'sd1);
  assign w_lf  = (w_ofs.dc == -2'sd1);
  assign w_rt  = (w_ofs.dc ==  2'sd1);

  assign tap_pad = (w_up & (i < IDX_W'(matrix))) |
                   (w_dn & (i >= lim_bot)) |
                   (w_lf & (prov == PROV_LEFT)) |
                   (w_rt & (prov == PROV_RIGHT));

  // Two's-complement sum wraps modulo 2^ADDR_W, matching the signed-then-truncate address.
  always_comb begin
    w_sum = base_addr + ADDR_W'(i);
    if (w_up) w_sum = w_sum - ADDR_W'(matrix);
    if (w_dn) w_sum = w_sum + ADDR_W'(matrix);
    if (w_lf) w_sum = w_sum - ADDR_W'(1);
    if (w_rt) w_sum = w_sum + ADDR_W'(1);
  end

  assign rd_addr = tap_pad ? '0 : w_sum;

endmodule

// File: rtl/conv_window_seq.sv
// Sequencer walking every pixel of a square feature map, handshaking with the
// border block for left/right edges and streaming nine window taps per pixel.
module conv_window_seq
  import conv_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 10,
  parameter int MAT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MAT_W-1:0]  matrix,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [IDX_W-1:0]  i,
  output logic              go,
  input  logic [1:0]        prov,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [3:0]        tap_idx,
  output logic              tap_pad,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              win_last,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [MAT_W-1:0]  r_mat;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_i, r_last, r_lim_bot;
  logic [3:0]        r_tap_idx;
  logic              r_go, r_tap_valid, r_busy, r_done;

  logic [MAT_W-1:0]  w_mat_eff;
  logic [IDX_W-1:0]  w_mat_x;
  logic              w_pad;
  logic [ADDR_W-1:0] w_addr;

  // A 1x1 map has no defined border behaviour, so it is widened to 2x2.
  assign w_mat_eff = (matrix < MAT_W'(2)) ? MAT_W'(2) : matrix;
  assign w_mat_x   = IDX_W'(w_mat_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mat       <= '0;
      r_base      <= '0;
      r_i         <= '0;
      r_last      <= '0;
      r_lim_bot   <= '0;
      r_tap_idx   <= '0;
      r_go        <= 1'b0;
      r_tap_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mat     <= w_mat_eff;
            r_base    <= base_addr;
            r_last    <= w_mat_x * w_mat_x - IDX_W'(1);
            r_lim_bot <= w_mat_x * (w_mat_x - IDX_W'(1));
            r_i       <= '0;
            r_go      <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_tap_idx   <= '0;
          r_tap_valid <= 1'b1;
          r_state     <= TAPS;
        end
        TAPS: begin
          if (tap_ready) begin
            if (r_tap_idx == TAP_LAST) begin
              r_tap_idx   <= '0;
              r_tap_valid <= 1'b0;
              if (r_i == r_last) begin
                r_go    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_i     <= r_i + IDX_W'(1);
                r_state <= LOOKUP;
              end
            end else begin
              r_tap_idx <= r_tap_idx + 4'd1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_i     <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  conv_tap_calc #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .MAT_W  (MAT_W)
  ) u_tap_calc (
    .tap_idx   (r_tap_idx),
    .i         (r_i),
    .matrix    (r_mat),
    .lim_bot   (r_lim_bot),
    .prov      (prov),
    .base_addr (r_base),
    .tap_pad   (w_pad),
    .rd_addr   (w_addr)
  );

  assign i         = r_i;
  assign go        = r_go;
  assign tap_valid = r_tap_valid;
  assign tap_idx   = r_tap_idx;
  assign tap_pad   = r_tap_valid & w_pad;
  assign rd_addr   = r_tap_valid ? w_addr : '0;
  assign rd_en     = r_tap_valid & tap_ready & ~w_pad;
  assign win_last  = (r_tap_idx == TAP_LAST);
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_conv_window_seq.sv
// Directed bench for conv_window_seq with a behavioural border model.
module tb_conv_window_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  matrix = '0;
  logic [12:0] base_addr = '0;
  logic [9:0]  i;
  logic        go;
  logic [1:0]  prov;
  logic        tap_valid;
  logic        tap_ready = 1'b1;
  logic [3:0]  tap_idx;
  logic        tap_pad;
  logic [12:0] rd_addr;
  logic        rd_en, win_last, busy, done;

  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0, done_cyc = -1, first_cyc = -1;
  int ndone = 0, ntaps = 0, exp_pix = 0, exp_tap = 0;
  int tb_mat = 3, tb_base = 0;
  bit mon_en = 0;
  bit pad_log [0:7055];
  int addr_log [0:7055];
  bit prev_stall = 0;
  logic [3:0]  prev_idx;
  logic        prev_pad;
  logic [12:0] prev_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix(matrix), .base_addr(base_addr),
    .i(i), .go(go), .prov(prov), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_idx(tap_idx), .tap_pad(tap_pad), .rd_addr(rd_addr), .rd_en(rd_en),
    .win_last(win_last), .busy(busy), .done(done)
  );

  // Border model: registers the column edge code while go is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) prov <= 2'b00;
    else if (go && tb_mat > 0) begin
      if ((int'(i) % tb_mat) == 0)               prov <= 2'b11;
      else if ((int'(i) % tb_mat) == tb_mat - 1) prov <= 2'b10;
      else                                       prov <= 2'b00;
    end else prov <= 2'b00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Tap monitor with an independent row/column reference.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (done) begin
        ndone++;
        done_cyc = cyc - t0;
      end
      if (tap_valid) begin
        int row, col, r, c, a, k;
        bit p;
        if (first_cyc < 0) first_cyc = cyc - t0;
        row = exp_pix / tb_mat;
        col = exp_pix % tb_mat;
        r = row + exp_tap / 3 - 1;
        c = col + exp_tap % 3 - 1;
        p = (r < 0) || (r >= tb_mat) || (c < 0) || (c >= tb_mat);
        a = p ? 0 : ((tb_base + r * tb_mat + c) % 8192);
        chk("tap_idx", tap_idx, exp_tap);
        chk("pix_i", i, exp_pix);
        chk("tap_pad", tap_pad, p);
        chk("rd_addr", rd_addr, a);
        chk("go_in_taps", go, 1);
        chk("win_last", win_last, exp_tap == 8);
        chk("rd_en", rd_en, tap_ready && !p);
        if (prev_stall) begin
          chk("stall_idx", tap_idx, prev_idx);
          chk("stall_pad", tap_pad, prev_pad);
          chk("stall_addr", rd_addr, prev_addr);
        end
        prev_stall = !tap_ready;
        prev_idx = tap_idx; prev_pad = tap_pad; prev_addr = rd_addr;
        if (tap_ready) begin
          k = exp_pix * 9 + exp_tap;
          if (k < 7056) begin
            pad_log[k] = tap_pad;
            addr_log[k] = rd_addr;
          end
          ntaps++;
          exp_tap++;
          if (exp_tap == 9) begin
            exp_tap = 0;
            exp_pix++;
          end
        end
      end else begin
        chk("rd_en_idle", rd_en, 0);
        prev_stall = 0;
      end
    end
  end

  task automatic begin_pass(input int m, input int b);
    @(posedge clk); #1;
    tb_mat = m; tb_base = b;
    matrix = 5'(m); base_addr = 13'(b);
    start = 1'b1; tap_ready = 1'b1;
    t0 = cyc; ndone = 0; ntaps = 0; exp_pix = 0; exp_tap = 0;
    done_cyc = -1; first_cyc = -1; prev_stall = 0; mon_en = 1;
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: extra start pulse mid-pass
  task automatic run_pass(input int m, input int b, input int mode);
    begin_pass(m, b);
    for (int k = 0; k < 20000 && ndone == 0; k++) begin
      @(posedge clk); #1;
      start = (mode == 2 && k == 30);
      if (mode == 1) tap_ready = ~tap_ready;
    end
    start = 1'b0; tap_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic chk_pads(input string tag, input int pix, input bit [8:0] exp_mask);
    for (int t = 0; t < 9; t++) chk(tag, pad_log[pix * 9 + t], exp_mask[t]);
  endtask

  initial begin
    #23;
    chk("rst_i", i, 0);
    chk("rst_go", go, 0);
    chk("rst_valid", tap_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_pad", tap_pad, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 3x3 map, base 100
    run_pass(3, 100, 0);
    chk("t1_done_cnt", ndone, 1);
    chk("t1_done_cyc", done_cyc, 91);
    chk("t1_first_tap", first_cyc, 2);
    chk("t1_taps", ntaps, 81);
    chk_pads("t1_pad_i0", 0, 9'b001_001_111);
    chk("t1_a4", addr_log[4], 100);
    chk("t1_a5", addr_log[5], 101);
    chk("t1_a7", addr_log[7], 103);
    chk("t1_a8", addr_log[8], 104);
    chk_pads("t1_pad_i4", 4, 9'b000_000_000);
    chk("t1_idle_busy", busy, 0);

    // 28x28 map, base 0
    run_pass(28, 0, 0);
    chk("t2_done_cnt", ndone, 1);
    chk("t2_done_cyc", done_cyc, 7841);
    chk_pads("t2_pad_i27", 27, 9'b100_100_111);
    chk_pads("t2_pad_i28", 28, 9'b001_001_001);
    chk_pads("t2_pad_i783", 783, 9'b111_100_100);

    // backpressure
    run_pass(3, 100, 1);
    chk("t3_done_cnt", ndone, 1);
    chk("t3_taps", ntaps, 81);

    // start re-pulsed mid-pass
    run_pass(3, 100, 2);
    chk("t4_done_cnt", ndone, 1);
    chk("t4_done_cyc", done_cyc, 91);
    chk("t4_busy_after", busy, 0);

    // reset in TAPS at pixel 5
    begin_pass(3, 100);
    for (int k = 0; k < 200 && !(exp_pix == 5 && exp_tap == 2); k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("t5_reached_i5", exp_pix, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_i", i, 0);
    chk("t5_rst_go", go, 0);
    chk("t5_rst_valid", tap_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_addr", rd_addr, 0);
    chk("t5_rst_rden", rd_en, 0);
    ndone = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", ndone, 0);
    chk("t5_idle", busy, 0);
    run_pass(3, 100, 0);
    chk("t5_done_cyc", done_cyc, 91);
    chk("t5_first_tap", first_cyc, 2);
    chk_pads("t5_pad_i0", 0, 9'b001_001_111);

    // address wrap
    run_pass(2, 8190, 0);
    chk("t6_done_cyc", done_cyc, 41);
    chk("t6_a_i0t4", addr_log[4], 8190);
    chk("t6_a_i3t4", addr_log[3 * 9 + 4], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
